// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: PC loop, instruction memory and decode handshake.
// master = fetch_sequencer, slave = PC register / memory / decode side.
interface fetch_sequencer_if #(
   parameter int AW = 12,
   parameter int DW = 16
);
   logic [AW-1:0] pc_in;
   logic [AW-1:0] pc_next;
   logic          pc_en;
   logic [AW-1:0] imem_addr;
   logic          imem_req;
   logic          imem_ack;
   logic [DW-1:0] imem_rdata;
   logic          branch_valid;
   logic [AW-1:0] branch_target;
   logic          stall;
   logic [DW-1:0] ir_out;
   logic [AW-1:0] ir_pc;
   logic          ir_valid;
   logic          ir_ready;
   logic          fetch_err;

   modport master (
      input  pc_in, imem_ack, imem_rdata, branch_valid,
      input  branch_target, stall, ir_ready,
      output pc_next, pc_en, imem_addr, imem_req,
      output ir_out, ir_pc, ir_valid, fetch_err
   );

   modport slave (
      output pc_in, imem_ack, imem_rdata, branch_valid,
      output branch_target, stall, ir_ready,
      input  pc_next, pc_en, imem_addr, imem_req,
      input  ir_out, ir_pc, ir_valid, fetch_err
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: launches imem reads from the PC, loads the
// instruction register and drives the PC update (PC+1 or branch target).
module fetch_sequencer #(
   parameter int AW       = 12,
   parameter int DW       = 16,
   parameter int MAX_WAIT = 15
) (
   input logic          clk,
   input logic          reset,
   fetch_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      WAIT,
      HOLD,
      ERR
   } state_t;

   localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);

   state_t     state;
   logic [7:0] cnt;
   logic       discard;
   logic       br_hold;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         discard       <= 1'b0;
         br_hold       <= 1'b0;
         bus.pc_next   <= '0;
         bus.pc_en     <= 1'b0;
         bus.imem_addr <= '0;
         bus.imem_req  <= 1'b0;
         bus.ir_out    <= '0;
         bus.ir_pc     <= '0;
         bus.ir_valid  <= 1'b0;
         bus.fetch_err <= 1'b0;
      end else begin
         bus.pc_en <= 1'b0;
         // A branch landing right after a pc_en pulse is deferred one
         // cycle so that pc_en never fires on back-to-back cycles.
         if (state != ERR) begin
            if (bus.branch_valid) begin
               bus.pc_next  <= bus.branch_target;
               bus.ir_valid <= 1'b0;
               bus.pc_en    <= !bus.pc_en;
               br_hold      <= bus.pc_en;
            end else if (br_hold) begin
               bus.pc_en <= 1'b1;
               br_hold   <= 1'b0;
            end
         end

         unique case (state)
            IDLE: begin
               if (!bus.branch_valid && !br_hold && !bus.stall)
                  state <= LAUNCH;
            end
            LAUNCH: begin
               if (bus.branch_valid) begin
                  state <= IDLE;
               end else begin
                  bus.imem_addr <= bus.pc_in;
                  bus.imem_req  <= 1'b1;
                  cnt           <= '0;
                  discard       <= 1'b0;
                  state         <= WAIT;
               end
            end
            WAIT: begin
               if (bus.imem_ack) begin
                  bus.imem_req <= 1'b0;
                  discard      <= 1'b0;
                  if (bus.branch_valid) begin
                     state <= IDLE;
                  end else if (discard) begin
                     // PC must settle before the next LAUNCH samples it
                     state <= br_hold ? IDLE : LAUNCH;
                  end else begin
                     bus.ir_out   <= bus.imem_rdata[DW-1:0];
                     bus.ir_pc    <= bus.imem_addr;
                     bus.ir_valid <= 1'b1;
                     bus.pc_next  <= bus.imem_addr + AW'(1);
                     bus.pc_en    <= 1'b1;
                     state        <= HOLD;
                  end
               end else if (cnt == LAST) begin
                  bus.imem_req  <= 1'b0;
                  bus.ir_valid  <= 1'b0;
                  bus.pc_en     <= 1'b0;
                  bus.fetch_err <= 1'b1;
                  br_hold       <= 1'b0;
                  state         <= ERR;
               end else begin
                  cnt <= cnt + 8'd1;
                  if (bus.branch_valid)
                     discard <= 1'b1;
               end
            end
            HOLD: begin
               if (bus.branch_valid) begin
                  state <= IDLE;
               end else if (bus.ir_ready) begin
                  bus.ir_valid <= 1'b0;
                  state        <= bus.stall ? IDLE : LAUNCH;
               end
            end
            ERR: begin
               bus.fetch_err <= 1'b1;
               bus.imem_req  <= 1'b0;
               bus.ir_valid  <= 1'b0;
               bus.pc_en     <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a
// randomized run against a transaction-level PC / fetch model.
module tb_fetch_sequencer;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   fetch_sequencer_if #(.AW(12), .DW(16)) bus ();

   fetch_sequencer #(.AW(12), .DW(16), .MAX_WAIT(15)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // environment state: PC register, memory responder, event logs
   int          n, w, dly, en_dbl;
   bit          no_ack, rnd_dly, pc_load;
   bit          en_last, req_last, irv_last;
   logic [11:0] pc_load_val;
   logic [11:0] q_req[$];
   logic [11:0] q_en[$];
   logic [11:0] q_ir[$];
   logic [15:0] q_iro[$];
   int          q_req_n[$];
   int          q_en_n[$];

   function automatic logic [15:0] mem(input logic [11:0] a);
      return {a[3:0], a} ^ 16'h5A3C;
   endfunction

   task automatic cyc();
      bit rise;
      @(posedge clk);
      #1;
      if (pc_load) bus.pc_in = pc_load_val;
      @(negedge clk);
      n++;
      pc_load     = bus.pc_en;
      pc_load_val = bus.pc_next;
      if (bus.pc_en && en_last) en_dbl++;
      en_last = bus.pc_en;
      if (bus.pc_en) begin
         q_en.push_back(bus.pc_next);
         q_en_n.push_back(n);
      end
      rise = bus.imem_req && !req_last;
      if (rise) begin
         q_req.push_back(bus.imem_addr);
         q_req_n.push_back(n);
         if (rnd_dly) dly = $urandom_range(0, 3);
      end
      req_last = bus.imem_req;
      if (bus.ir_valid && !irv_last) begin
         q_ir.push_back(bus.ir_pc);
         q_iro.push_back(bus.ir_out);
      end
      irv_last = bus.ir_valid;
      bus.imem_ack = 1'b0;
      if (bus.imem_req) begin
         if (!no_ack && w >= dly) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = mem(bus.imem_addr);
            w = 0;
         end else begin
            w++;
         end
      end
   endtask

   task automatic restart(input logic [11:0] pc);
      reset = 1'b1;
      bus.imem_ack      = 1'b0;
      bus.imem_rdata    = '0;
      bus.branch_valid  = 1'b0;
      bus.branch_target = '0;
      bus.stall         = 1'b0;
      bus.ir_ready      = 1'b1;
      bus.pc_in         = pc;
      pc_load = 0; w = 0; n = 0; dly = 0; en_dbl = 0;
      no_ack = 0; rnd_dly = 0;
      en_last = 0; req_last = 0; irv_last = 0;
      q_req.delete(); q_req_n.delete();
      q_en.delete(); q_en_n.delete();
      q_ir.delete(); q_iro.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [3:0]  ctl;
      logic [51:0] dat;
      reset = 1'b1;
      @(negedge clk);
      ctl = {bus.pc_en, bus.imem_req, bus.ir_valid, bus.fetch_err};
      dat = {bus.pc_next, bus.imem_addr, bus.ir_out, bus.ir_pc};
      total++;
      if (ctl !== 4'h0) begin
         bad++;
         $display("FAIL reset_ctl: got %b want 0000", ctl);
      end
      total++;
      if (dat !== '0) begin
         bad++;
         $display("FAIL reset_data: got %h want 0", dat);
      end
   endtask

   task automatic test_cadence();
      restart(12'h000);
      repeat (12) cyc();
      total++;
      if (q_req.size() < 3 || q_req[0] !== 12'h000 ||
          q_req[1] !== 12'h001 || q_req[2] !== 12'h002) begin
         bad++;
         $display("FAIL cadence_addr: got %p want 000 001 002", q_req);
      end
      total++;
      if (q_req_n.size() < 3 || q_req_n[0] != 2 ||
          q_req_n[1] != 5 || q_req_n[2] != 8) begin
         bad++;
         $display("FAIL cadence_cycles: got %p want 2 5 8", q_req_n);
      end
      total++;
      if (q_ir.size() < 1 || q_ir[0] !== 12'h000 || q_iro[0] !== mem(12'h000)) begin
         bad++;
         $display("FAIL cadence_ir: got %p %p want 000 %h", q_ir, q_iro, mem(12'h000));
      end
      total++;
      if (q_en.size() < 1 || q_en[0] !== 12'h001 || q_en_n[0] != 3 || en_dbl != 0) begin
         bad++;
         $display("FAIL cadence_pc_en: got %p at %p dbl=%0d want 001 at 3", q_en, q_en_n, en_dbl);
      end
   endtask

   task automatic test_wrap();
      restart(12'hFFF);
      repeat (8) cyc();
      total++;
      if (q_en.size() < 1 || q_en[0] !== 12'h000) begin
         bad++;
         $display("FAIL wrap_pc_next: got %p want 000", q_en);
      end
      total++;
      if (q_req.size() < 2 || q_req[0] !== 12'hFFF || q_req[1] !== 12'h000) begin
         bad++;
         $display("FAIL wrap_addr: got %p want fff 000", q_req);
      end
   endtask

   task automatic test_delay();
      int reqc, abad;
      restart(12'h010);
      dly = 4;
      reqc = 0; abad = 0;
      repeat (8) begin
         cyc();
         if (bus.imem_req) begin
            reqc++;
            if (bus.imem_addr !== 12'h010) abad++;
         end
      end
      total++;
      if (reqc != 5 || abad != 0) begin
         bad++;
         $display("FAIL delay_req: got %0d cycles %0d bad addr want 5 0", reqc, abad);
      end
      total++;
      if (q_ir.size() != 1 || q_ir[0] !== 12'h010 || q_iro[0] !== mem(12'h010)) begin
         bad++;
         $display("FAIL delay_ir: got %p %p want 010 %h", q_ir, q_iro, mem(12'h010));
      end
   endtask

   task automatic test_timeout();
      int reqc, leak;
      restart(12'h020);
      no_ack = 1;
      reqc = 0;
      repeat (20) begin
         cyc();
         if (bus.imem_req) reqc++;
      end
      total++;
      if (reqc != 15 || bus.fetch_err !== 1'b1 || bus.imem_req !== 1'b0) begin
         bad++;
         $display("FAIL timeout: got req=%0d err=%b req_now=%b want 15 1 0",
                  reqc, bus.fetch_err, bus.imem_req);
      end
      no_ack = 0;
      leak = 0;
      repeat (10) begin
         cyc();
         if (bus.fetch_err !== 1'b1 || bus.ir_valid !== 1'b0) leak++;
      end
      total++;
      if (leak != 0 || q_req.size() != 1 || q_en.size() != 0) begin
         bad++;
         $display("FAIL err_sticky: got leak=%0d reqs=%0d pc_en=%0d want 0 1 0",
                  leak, q_req.size(), q_en.size());
      end
   endtask

   task automatic test_branch_wait();
      restart(12'h050);
      dly = 2;
      cyc();
      cyc();
      total++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 12'h050) begin
         bad++;
         $display("FAIL br_pre: got req=%b addr=%h want 1 050", bus.imem_req, bus.imem_addr);
      end
      bus.branch_target = 12'h200;
      bus.branch_valid  = 1'b1;
      cyc();
      bus.branch_valid  = 1'b0;
      total++;
      if (bus.pc_en !== 1'b1 || bus.pc_next !== 12'h200) begin
         bad++;
         $display("FAIL br_pc_en: got en=%b next=%h want 1 200", bus.pc_en, bus.pc_next);
      end
      repeat (8) cyc();
      total++;
      if (q_ir.size() < 1 || q_ir[0] !== 12'h200 || q_iro[0] !== mem(12'h200)) begin
         bad++;
         $display("FAIL br_discard: got %p want first ir_pc 200", q_ir);
      end
      total++;
      if (q_req.size() < 2 || q_req[1] !== 12'h200 ||
          q_en.size() < 2 || q_en[0] !== 12'h200 || q_en[1] !== 12'h201) begin
         bad++;
         $display("FAIL br_refetch: got req %p en %p want 050 200 / 200 201", q_req, q_en);
      end
   endtask

   task automatic test_hold_stall();
      logic [15:0] held;
      restart(12'h040);
      bus.ir_ready = 1'b0;
      repeat (3) cyc();
      held = bus.ir_out;
      total++;
      if (bus.ir_valid !== 1'b1 || held !== mem(12'h040)) begin
         bad++;
         $display("FAIL hold_load: got v=%b ir=%h want 1 %h", bus.ir_valid, held, mem(12'h040));
      end
      repeat (5) begin
         cyc();
         total++;
         if (bus.ir_valid !== 1'b1 || bus.ir_out !== held || q_req.size() != 1) begin
            bad++;
            $display("FAIL hold_stable: got v=%b ir=%h reqs=%0d want 1 %h 1",
                     bus.ir_valid, bus.ir_out, q_req.size(), held);
         end
      end
      bus.ir_ready = 1'b1;
      bus.stall    = 1'b1;
      cyc();
      bus.ir_ready = 1'b0;
      repeat (4) cyc();
      total++;
      if (bus.ir_valid !== 1'b0 || q_req.size() != 1) begin
         bad++;
         $display("FAIL stall_idle: got v=%b reqs=%0d want 0 1", bus.ir_valid, q_req.size());
      end
      bus.stall = 1'b0;
      repeat (4) cyc();
      total++;
      if (q_req.size() != 2 || q_req[1] !== 12'h041) begin
         bad++;
         $display("FAIL stall_resume: got %p want 040 041", q_req);
      end
   endtask

   task automatic test_async_reset();
      logic [3:0] ctl;
      restart(12'h300);
      no_ack = 1;
      repeat (4) cyc();
      total++;
      if (bus.imem_req !== 1'b1) begin
         bad++;
         $display("FAIL areset_pre: got req=%b want 1", bus.imem_req);
      end
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      ctl = {bus.imem_req, bus.ir_valid, bus.pc_en, bus.fetch_err};
      total++;
      if (ctl !== 4'h0) begin
         bad++;
         $display("FAIL areset_async: got %b want 0000", ctl);
      end
      restart(12'h300);
      repeat (4) cyc();
      total++;
      if (q_req.size() != 1 || q_req[0] !== 12'h300) begin
         bad++;
         $display("FAIL areset_restart: got %p want 300", q_req);
      end
   endtask

   task automatic test_random();
      logic [11:0] exp_pc, fa, tgt, br_tgt, addr_prev, e;
      logic [11:0] q_exp[$];
      bit          inflight, br, br_prev, req_prev, irv_prev;
      int          br_dl, nfetch;
      exp_pc = 12'($urandom);
      restart(exp_pc);
      rnd_dly = 1;
      inflight = 0; br_prev = 0; req_prev = 0; irv_prev = 0;
      br_dl = 0; nfetch = 0; fa = exp_pc; addr_prev = '0; br_tgt = '0;
      for (int i = 0; i < 2000; i++) begin
         cyc();
         if (bus.pc_en) begin
            total++;
            if (bus.pc_next !== exp_pc) begin
               bad++;
               $display("FAIL rnd_pc_next: got %h want %h cyc %0d", bus.pc_next, exp_pc, n);
            end
         end
         if (br_dl > 0) begin
            if (bus.pc_en && bus.pc_next === br_tgt) begin
               br_dl = 0;
               total++;
            end else begin
               br_dl--;
               if (br_dl == 0) begin
                  total++;
                  bad++;
                  $display("FAIL rnd_branch: no pc_en for target %h by cyc %0d", br_tgt, n);
               end
            end
         end
         if (bus.imem_req && !req_prev) begin
            fa = exp_pc;
            total++;
            if (bus.imem_addr !== exp_pc) begin
               bad++;
               $display("FAIL rnd_req_addr: got %h want %h cyc %0d", bus.imem_addr, exp_pc, n);
            end
         end else if (bus.imem_req && bus.imem_addr !== addr_prev) begin
            total++;
            bad++;
            $display("FAIL rnd_addr_hold: got %h want %h cyc %0d", bus.imem_addr, addr_prev, n);
         end
         req_prev  = bus.imem_req;
         addr_prev = bus.imem_addr;
         if (bus.ir_valid && !irv_prev) begin
            total++;
            if (q_exp.size() == 0) begin
               bad++;
               $display("FAIL rnd_ir_extra: got ir_pc %h want none cyc %0d", bus.ir_pc, n);
            end else begin
               e = q_exp.pop_front();
               nfetch++;
               if (bus.ir_pc !== e || bus.ir_out !== mem(e)) begin
                  bad++;
                  $display("FAIL rnd_ir: got %h/%h want %h/%h cyc %0d",
                           bus.ir_pc, bus.ir_out, e, mem(e), n);
               end
            end
         end
         irv_prev = bus.ir_valid;
         br  = !br_prev && ($urandom_range(0, 15) == 0);
         tgt = 12'($urandom);
         bus.branch_valid  = br;
         bus.branch_target = tgt;
         bus.ir_ready      = ($urandom_range(0, 9) < 7);
         bus.stall         = ($urandom_range(0, 9) < 2);
         if (bus.imem_ack) begin
            if (!inflight && !br) begin
               q_exp.push_back(fa);
               exp_pc = fa + 12'd1;
            end
            inflight = 0;
         end
         if (br) begin
            exp_pc = tgt;
            br_tgt = tgt;
            br_dl  = 2;
            if (bus.imem_req && !bus.imem_ack) inflight = 1;
         end
         br_prev = br;
      end
      bus.branch_valid = 1'b0;
      rnd_dly = 0;
      total++;
      if (en_dbl != 0 || q_exp.size() > 1 || nfetch < 100) begin
         bad++;
         $display("FAIL rnd_summary: got dbl=%0d left=%0d fetched=%0d want 0 <=1 >=100",
                  en_dbl, q_exp.size(), nfetch);
      end
   endtask

   initial begin
      reset             = 1'b0;
      bus.pc_in         = '0;
      bus.imem_ack      = 1'b0;
      bus.imem_rdata    = '0;
      bus.branch_valid  = 1'b0;
      bus.branch_target = '0;
      bus.stall         = 1'b0;
      bus.ir_ready      = 1'b1;
      test_reset();
      test_cadence();
      test_wrap();
      test_delay();
      test_timeout();
      test_branch_wait();
      test_hold_stall();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
